// File: rtl/spi_ram_burst_if.sv
// Command/response bus between the SPI deserialiser/serialiser and spi_ram_burst.
// The command side and the response side each use a ready/valid handshake.
interface spi_ram_burst_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output din, rx_valid, tx_ready,
    input  rx_ready, dout, tx_valid
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output rx_ready, dout, tx_valid
  );
endinterface

// File: rtl/spi_ram_burst.sv
// Command-decoded single-port RAM with optional burst addressing, a ready/valid
// response register, and a zero-fill sweep of the whole array after reset.
module spi_ram_burst #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter bit          AUTO_INC       = 1'b1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_burst_if.slave bus,
  output logic           busy_o
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WRITE     = 2'b01,
    OP_SET_RADDR = 2'b10,
    OP_READ      = 2'b11
  } op_e;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
  logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  op_e               opcode;
  logic [DATA_W-1:0] payload;
  logic              clearing;
  logic              rx_ready;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;

  assign opcode  = op_e'(bus.din[DATA_W+1:DATA_W]);
  assign payload = bus.din[DATA_W-1:0];
  assign accept  = bus.rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clr_addr_q == '1) begin
      state_d = ST_RUN;
    end
  end

  // A pending response blocks every opcode, not just READ, so ordering is kept.
  always_comb begin
    clearing = (state_q == ST_CLEAR);
    busy_o   = clearing;
    rx_ready = !clearing && (!tx_valid_q || bus.tx_ready);
  end

  always_comb begin
    clr_addr_d = clr_addr_q;
    addr_wr_d  = addr_wr_q;
    addr_rd_d  = addr_rd_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_wr_q;
    mem_wdata  = payload;
    rd_en      = 1'b0;
    if (clearing) begin
      mem_we     = 1'b1;
      mem_waddr  = clr_addr_q;
      mem_wdata  = '0;
      clr_addr_d = clr_addr_q + ADDR_W'(1);
    end else if (accept) begin
      unique case (opcode)
        OP_SET_WADDR: addr_wr_d = payload[ADDR_W-1:0];
        OP_WRITE: begin
          mem_we = 1'b1;
          if (AUTO_INC) addr_wr_d = addr_wr_q + ADDR_W'(1);
        end
        OP_SET_RADDR: addr_rd_d = payload[ADDR_W-1:0];
        OP_READ: begin
          rd_en = 1'b1;
          if (AUTO_INC) addr_rd_d = addr_rd_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    if (tx_valid_q && bus.tx_ready) tx_valid_d = 1'b0;
    if (rd_en) begin
      dout_d     = mem_q[addr_rd_q];
      tx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q <= '0;
      addr_wr_q  <= '0;
      addr_rd_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      clr_addr_q <= clr_addr_d;
      addr_wr_q  <= addr_wr_d;
      addr_rd_q  <= addr_rd_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Array has no reset so it stays RAM-inferable; the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.rx_ready = rx_ready;
  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: default 8/8 burst instance plus a 16/4 fixed-address one.
module tb_spi_ram_burst;
  logic clk = 1'b0;
  logic rst_n;
  logic busy8, busy16;

  spi_ram_burst_if #(.DATA_W(8))  b8 ();
  spi_ram_burst_if #(.DATA_W(16)) b16 ();

  spi_ram_burst u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (b8),
    .busy_o (busy8)
  );

  spi_ram_burst #(
    .DATA_W        (16),
    .ADDR_W        (4),
    .AUTO_INC      (1'b0),
    .CLEAR_ON_RESET(1'b1)
  ) u_dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (b16),
    .busy_o (busy16)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [15:0] exp8_q[$];
  logic [15:0] exp16_q[$];
  logic        rdy8, rdy16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (scoreboard pops on consumed responses), end at posedge+1.
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    rdy8  = b8.rx_ready;
    rdy16 = b16.rx_ready;
    if (b8.tx_valid && b8.tx_ready) begin
      n_checks++;
      assert (exp8_q.size() != 0) else begin
        n_err++;
        $error("FAIL rsp8_unexpected: observed response %0h, expected none", b8.dout);
      end
      if (exp8_q.size() != 0) begin
        e = exp8_q.pop_front();
        chk("rsp8", 32'(b8.dout), 32'(e));
      end
    end
    if (b16.tx_valid && b16.tx_ready) begin
      n_checks++;
      assert (exp16_q.size() != 0) else begin
        n_err++;
        $error("FAIL rsp16_unexpected: observed response %0h, expected none", b16.dout);
      end
      if (exp16_q.size() != 0) begin
        e = exp16_q.pop_front();
        chk("rsp16", 32'(b16.dout), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input bit sel, input logic [1:0] op, input logic [15:0] pl,
                     input logic [15:0] exp);
    int unsigned n = 0;
    logic        acc;
    if (sel) begin
      b16.din      = {op, pl};
      b16.rx_valid = 1'b1;
    end else begin
      b8.din      = {op, pl[7:0]};
      b8.rx_valid = 1'b1;
    end
    do begin
      step();
      n++;
      acc = sel ? rdy16 : rdy8;
    end while (!acc && n < 1000);
    b8.rx_valid  = 1'b0;
    b16.rx_valid = 1'b0;
    n_checks++;
    assert (acc) else begin
      n_err++;
      $error("FAIL cmd_timeout: observed rx_ready 0 for %0d cycles, expected acceptance", n);
    end
    if (acc && op == 2'b11) begin
      if (sel) begin
        exp16_q.push_back(exp);
        chk("rd_lat16_valid", 32'(b16.tx_valid), 32'd1);
      end else begin
        exp8_q.push_back(exp);
        chk("rd_lat8_valid", 32'(b8.tx_valid), 32'd1);
      end
    end
  endtask

  task automatic drain();
    repeat (3) step();
    chk("q8_empty", 32'(exp8_q.size()), 32'd0);
    chk("q16_empty", 32'(exp16_q.size()), 32'd0);
  endtask

  // Called at posedge+1 right after reset release.
  task automatic sweep_check();
    int unsigned cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (busy8 && !b8.rx_ready) cnt++;
      @(posedge clk);
    end
    #1;
    chk("sweep_cycles", 32'(cnt), 32'd256);
    @(negedge clk);
    chk("sweep_busy_low", 32'(busy8), 32'd0);
    chk("sweep_rdy_high", 32'(b8.rx_ready), 32'd1);
    chk("sweep16_busy_low", 32'(busy16), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    b8.din       = '0;
    b8.rx_valid  = 1'b0;
    b8.tx_ready  = 1'b1;
    b16.din      = '0;
    b16.rx_valid = 1'b0;
    b16.tx_ready = 1'b1;
    #3;
    chk("rst_dout", 32'(b8.dout), 32'd0);
    chk("rst_tx_valid", 32'(b8.tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(b8.rx_ready), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd1);
    chk("rst_busy16", 32'(busy16), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep_check();

    cmd(0, 2'b10, 16'h05, 16'h00);
    cmd(0, 2'b11, 16'h00, 16'h00);

    cmd(0, 2'b00, 16'h10, 16'h00);
    cmd(0, 2'b01, 16'hA5, 16'h00);
    cmd(0, 2'b10, 16'h10, 16'h00);
    cmd(0, 2'b11, 16'h00, 16'hA5);

    cmd(0, 2'b00, 16'hFE, 16'h00);
    cmd(0, 2'b01, 16'h11, 16'h00);
    cmd(0, 2'b01, 16'h22, 16'h00);
    cmd(0, 2'b01, 16'h33, 16'h00);
    cmd(0, 2'b10, 16'hFE, 16'h00);
    cmd(0, 2'b11, 16'h00, 16'h11);
    cmd(0, 2'b11, 16'h00, 16'h22);
    cmd(0, 2'b11, 16'h00, 16'h33);
    drain();

    b8.tx_ready = 1'b0;
    cmd(0, 2'b10, 16'h10, 16'h00);
    cmd(0, 2'b11, 16'h00, 16'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_tx_valid", 32'(b8.tx_valid), 32'd1);
      chk("bp_rx_ready", 32'(b8.rx_ready), 32'd0);
      chk("bp_dout", 32'(b8.dout), 32'hA5);
      @(posedge clk);
      #1;
    end
    b8.tx_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(b8.rx_ready), 32'd1);
    drain();

    b8.tx_ready = 1'b0;
    cmd(0, 2'b10, 16'h10, 16'h00);
    cmd(0, 2'b11, 16'h00, 16'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(b8.tx_valid), 32'd0);
    chk("arst_dout", 32'(b8.dout), 32'd0);
    chk("arst_busy", 32'(busy8), 32'd1);
    chk("arst_rx_ready", 32'(b8.rx_ready), 32'd0);
    exp8_q.delete();
    b8.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep_check();
    cmd(0, 2'b10, 16'h10, 16'h00);
    cmd(0, 2'b11, 16'h00, 16'h00);
    drain();

    cmd(1, 2'b00, 16'hFFF3, 16'h0000);
    cmd(1, 2'b01, 16'hBEEF, 16'h0000);
    cmd(1, 2'b01, 16'h1234, 16'h0000);
    cmd(1, 2'b10, 16'h0003, 16'h0000);
    cmd(1, 2'b11, 16'h0000, 16'h1234);
    cmd(1, 2'b11, 16'h0000, 16'h1234);
    cmd(1, 2'b11, 16'h0000, 16'h1234);
    cmd(1, 2'b10, 16'h0004, 16'h0000);
    cmd(1, 2'b11, 16'h0000, 16'h0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
